// File: rtl/lock_pkg.sv
// Shared types and helpers for the digital lock sequencing controller:
// FSM state encoding, BCD digit constants and one-hot LED encoders.
package lock_pkg;

  localparam int         DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [2:0] {
    ST_ENTRY,
    ST_CHECK,
    ST_OPEN,
    ST_CHANGE,
    ST_LOCKOUT
  } lock_state_t;

  // Tries used shown one-hot; zero tries lights nothing.
  function automatic logic [2:0] led_try_enc(input logic [1:0] tries);
    case (tries)
      2'd1:    return 3'b001;
      2'd2:    return 3'b010;
      2'd3:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // Rounds used shown one-hot; zero rounds lights the first LED.
  function automatic logic [3:0] led_round_enc(input logic [1:0] rounds);
    return 4'b0001 << rounds;
  endfunction

endpackage

// File: rtl/lock_tick_gen.sv
// Countdown tick divider: emits a 1-cycle tick every TICK_DIV clocks,
// phase-aligned to the last synchronous restart.
module lock_tick_gen #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (restart) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CW'(TICK_DIV - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/lock_seq_ctrl.sv
// Digital lock sequencer: code entry, password check, tries/rounds/lockout
// and password change. Define LOCK_ESCALATE_EN for escalating lockout length.
module lock_seq_ctrl
  import lock_pkg::*;
#(
  parameter int                       DIGITS     = 4,
  parameter int                       MAX_TRIES  = 3,
  parameter int                       MAX_ROUNDS = 3,
  parameter int                       LOCK_SECS  = 5,
  parameter int                       TICK_DIV   = 50000000,
  parameter logic [4*DIGITS-1:0]      DEF_PASS   = 16'h1234
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit,
  input  logic       enter,
  input  logic       mode,
  input  logic       relock,
  output logic       unlocked,
  output logic       lockout,
  output logic       def_mode,
  output logic [3:0] count_down,
  output logic [2:0] led_try,
  output logic [3:0] led_round,
  output logic [1:0] digit_idx,
  output logic       pass_ok,
  output logic       pass_bad
);

  localparam int CODE_W = DIGITS * DIGIT_W;

  lock_state_t       state, state_nxt;
  logic              enter_d, press_q;
  logic [3:0]        digit_q;
  logic [CODE_W-1:0] code, pass_reg, code_nxt;
  logic [1:0]        idx, tries, rounds, rounds_inc;
  logic              def_q;
  logic [3:0]        cd, lock_len;
  logic              tick, restart, press_v, last_digit, match, lock_done;

  // Rising-edge detect; the press and its digit act one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enter_d <= 1'b0;
      press_q <= 1'b0;
      digit_q <= '0;
    end else begin
      enter_d <= enter;
      press_q <= enter & ~enter_d;
      digit_q <= digit;
    end
  end

  assign press_v    = press_q && (digit_q <= BCD_MAX);
  assign last_digit = press_v && (idx == 2'(DIGITS - 1));
  assign code_nxt   = {code[CODE_W-DIGIT_W-1:0], digit_q};
  assign match      = def_q ? (code == DEF_PASS) : (code == pass_reg);
  assign rounds_inc = (rounds == 2'(MAX_ROUNDS)) ? rounds : rounds + 2'd1;
  assign lock_done  = tick && (cd <= 4'd1);
  assign restart    = (state_nxt == ST_LOCKOUT) && (state != ST_LOCKOUT);

`ifdef LOCK_ESCALATE_EN
  int esc_prod;
  always_comb begin
    esc_prod = LOCK_SECS * int'(rounds_inc);
    lock_len = (def_q || esc_prod > 15) ? 4'd15 : 4'(esc_prod);
  end
`else
  assign lock_len = 4'(LOCK_SECS);
`endif

  lock_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_ENTRY;
    else        state <= state_nxt;
  end

  // NOTE: every comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_ENTRY:   if (last_digit) state_nxt = ST_CHECK;
      ST_CHECK: begin
        if (match)                               state_nxt = ST_OPEN;
        else if (def_q)                          state_nxt = ST_LOCKOUT;
        else if (tries == 2'(MAX_TRIES - 1))     state_nxt = ST_LOCKOUT;
        else                                     state_nxt = ST_ENTRY;
      end
      ST_OPEN: begin
        if (relock)               state_nxt = ST_ENTRY;
        else if (press_q && mode) state_nxt = ST_CHANGE;
      end
      ST_CHANGE:  if (relock || last_digit) state_nxt = ST_ENTRY;
      ST_LOCKOUT: if (lock_done) state_nxt = ST_ENTRY;
      default:    state_nxt = ST_ENTRY;
    endcase
  end

  // NOTE: the stored password is a plain register with a reset value, so an
  // async reset restores DEF_PASS rather than leaving it undefined.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code     <= '0;
      pass_reg <= DEF_PASS;
      idx      <= '0;
      tries    <= '0;
      rounds   <= '0;
      def_q    <= 1'b0;
      cd       <= '0;
    end else begin
      case (state)
        ST_ENTRY: if (press_v) begin
          code <= code_nxt;
          idx  <= last_digit ? 2'd0 : idx + 2'd1;
        end
        ST_CHECK: begin
          if (match) begin
            tries  <= '0;
            rounds <= '0;
            def_q  <= 1'b0;
          end else if (!def_q) begin
            if (tries == 2'(MAX_TRIES - 1)) begin
              tries  <= '0;
              rounds <= rounds_inc;
            end else begin
              tries <= tries + 2'd1;
            end
          end
          if (state_nxt == ST_LOCKOUT) cd <= lock_len;
        end
        ST_CHANGE: begin
          if (relock) begin
            idx <= '0;
          end else if (press_v) begin
            code <= code_nxt;
            idx  <= last_digit ? 2'd0 : idx + 2'd1;
            if (last_digit) pass_reg <= code_nxt;
          end
        end
        ST_LOCKOUT: begin
          if (tick && cd != 4'd0) cd <= cd - 4'd1;
          if (lock_done && rounds == 2'(MAX_ROUNDS)) def_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  logic       unlocked_c, lockout_c, ok_c, bad_c;
  logic [3:0] cd_c, led_round_c;
  logic [2:0] led_try_c;

  always_comb begin
    unlocked_c  = (state == ST_OPEN) || (state == ST_CHANGE);
    lockout_c   = (state == ST_LOCKOUT);
    cd_c        = lockout_c ? cd : 4'd0;
    led_try_c   = led_try_enc(tries);
    led_round_c = led_round_enc(rounds);
    ok_c        = (state == ST_CHECK) && match;
    bad_c       = (state == ST_CHECK) && !match;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      unlocked   <= 1'b0;
      lockout    <= 1'b0;
      def_mode   <= 1'b0;
      count_down <= '0;
      led_try    <= '0;
      led_round  <= 4'b0001;
      digit_idx  <= '0;
      pass_ok    <= 1'b0;
      pass_bad   <= 1'b0;
    end else begin
      unlocked   <= unlocked_c;
      lockout    <= lockout_c;
      def_mode   <= def_q;
      count_down <= cd_c;
      led_try    <= led_try_c;
      led_round  <= led_round_c;
      digit_idx  <= idx;
      pass_ok    <= ok_c;
      pass_bad   <= bad_c;
    end
  end

endmodule

// File: tb/tb_lock_seq_ctrl.sv
// Directed bench for lock_seq_ctrl with a fast tick divider; expected
// values are hand-derived. Honours LOCK_ESCALATE_EN for lockout lengths.
module tb_lock_seq_ctrl;

  localparam int TICK_DIV  = 4;
  localparam int LOCK_SECS = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] digit = '0;
  logic       enter = 1'b0, mode = 1'b0, relock = 1'b0;
  logic       unlocked, lockout, def_mode, pass_ok, pass_bad;
  logic [3:0] count_down, led_round;
  logic [2:0] led_try;
  logic [1:0] digit_idx;

  lock_seq_ctrl #(
    .DIGITS(4), .MAX_TRIES(3), .MAX_ROUNDS(3), .LOCK_SECS(LOCK_SECS),
    .TICK_DIV(TICK_DIV), .DEF_PASS(16'h1234)
  ) dut (
    .clk(clk), .rst_n(rst_n), .digit(digit), .enter(enter), .mode(mode),
    .relock(relock), .unlocked(unlocked), .lockout(lockout),
    .def_mode(def_mode), .count_down(count_down), .led_try(led_try),
    .led_round(led_round), .digit_idx(digit_idx), .pass_ok(pass_ok),
    .pass_bad(pass_bad)
  );

  always #5 clk = ~clk;

  int   n_tests = 0, n_fail = 0;
  int   ok_cnt = 0, bad_cnt = 0, lock_run = 0;
  int   ok0, bad0, len;
  logic lk_prev = 1'b0;

  // Pulse counters and length of the most recent lockout, in clocks.
  always @(negedge clk) begin
    if (pass_ok)  ok_cnt++;
    if (pass_bad) bad_cnt++;
    if (lockout && !lk_prev) lock_run = 1;
    else if (lockout)        lock_run++;
    lk_prev = lockout;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic press(input logic [3:0] d);
    digit = d;
    enter = 1'b1;
    repeat (2) @(negedge clk);
    enter = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic enter_code(input logic [15:0] c);
    for (int i = 3; i >= 0; i--) press(c[i*4 +: 4]);
  endtask

  task automatic wait_end();
    int n = 0;
    while (lockout && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (lockout) check("lockout_timeout", 32'(lockout), 32'd0);
  endtask

  function automatic int exp_len(input int r, input bit dm);
`ifdef LOCK_ESCALATE_EN
    if (dm) return 15;
    return (LOCK_SECS * r > 15) ? 15 : LOCK_SECS * r;
`else
    return LOCK_SECS;
`endif
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_led_round_in_reset", 32'(led_round), 32'h1);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_unlocked",   32'(unlocked),   32'd0);
    check("rst_lockout",    32'(lockout),    32'd0);
    check("rst_def_mode",   32'(def_mode),   32'd0);
    check("rst_count_down", 32'(count_down), 32'd0);
    check("rst_led_try",    32'(led_try),    32'd0);
    check("rst_led_round",  32'(led_round),  32'h1);
    check("rst_digit_idx",  32'(digit_idx),  32'd0);

    press(4'd12);
    check("bad_digit_idx", 32'(digit_idx), 32'd0);
    press(4'd1);
    check("idx_after_one", 32'(digit_idx), 32'd1);
    ok0 = ok_cnt;
    press(4'd2); press(4'd3); press(4'd4);
    check("first_pass_ok",  32'(ok_cnt - ok0), 32'd1);
    check("first_unlocked", 32'(unlocked),     32'd1);
    check("first_led_try",  32'(led_try),      32'd0);
    check("first_idx_clr",  32'(digit_idx),    32'd0);

    relock = 1'b1;
    repeat (3) @(negedge clk);
    relock = 1'b0;
    check("relock_locked", 32'(unlocked), 32'd0);

    // Round 1 of wrong codes.
    bad0 = bad_cnt;
    enter_code(16'h1235);
    check("wrong1_bad",     32'(bad_cnt - bad0), 32'd1);
    check("wrong1_led_try", 32'(led_try),        32'b001);
    enter_code(16'h1235);
    check("wrong2_led_try", 32'(led_try),        32'b010);
    enter_code(16'h1235);
    check("wrong3_bad",     32'(bad_cnt - bad0), 32'd3);
    check("r1_lockout",     32'(lockout),        32'd1);
    check("r1_count_down",  32'(count_down),     32'(exp_len(1, 1'b0)));
    check("r1_led_try",     32'(led_try),        32'd0);
    press(4'd7);
    check("lockout_press_idx", 32'(digit_idx), 32'd0);
    len = exp_len(1, 1'b0) * TICK_DIV;
    wait_end();
    check("r1_len",        32'(lock_run >= len && lock_run <= len + 2), 32'd1);
    check("r1_cd_zero",    32'(count_down), 32'd0);
    check("r1_led_round",  32'(led_round),  32'b0010);
    check("r1_idx",        32'(digit_idx),  32'd0);

    for (int r = 2; r <= 3; r++) begin
      repeat (3) enter_code(16'h1235);
      check("rn_lockout",    32'(lockout),    32'd1);
      check("rn_count_down", 32'(count_down), 32'(exp_len(r, 1'b0)));
      len = exp_len(r, 1'b0) * TICK_DIV;
      wait_end();
      check("rn_len",        32'(lock_run >= len && lock_run <= len + 2), 32'd1);
      check("rn_led_round",  32'(led_round), 32'(4'b0001 << r));
    end
    check("def_mode_set", 32'(def_mode), 32'd1);

    bad0 = bad_cnt;
    enter_code(16'h1235);
    check("def_wrong_bad",     32'(bad_cnt - bad0), 32'd1);
    check("def_wrong_lockout", 32'(lockout),        32'd1);
    check("def_count_down",    32'(count_down),     32'(exp_len(3, 1'b1)));
    wait_end();
    check("def_mode_kept", 32'(def_mode), 32'd1);
    ok0 = ok_cnt;
    enter_code(16'h1234);
    check("def_pass_ok",   32'(ok_cnt - ok0), 32'd1);
    check("def_cleared",   32'(def_mode),     32'd0);
    check("def_led_round", 32'(led_round),    32'h1);
    check("def_unlocked",  32'(unlocked),     32'd1);

    // Password change to 9876.
    mode = 1'b1;
    press(4'd0);
    mode = 1'b0;
    check("change_unlocked", 32'(unlocked),  32'd1);
    check("change_idx0",     32'(digit_idx), 32'd0);
    press(4'd9); press(4'd8); press(4'd7);
    check("change_idx3", 32'(digit_idx), 32'd3);
    press(4'd6);
    check("change_done_locked", 32'(unlocked), 32'd0);
    bad0 = bad_cnt;
    enter_code(16'h1234);
    check("old_pass_bad", 32'(bad_cnt - bad0), 32'd1);
    ok0 = ok_cnt;
    enter_code(16'h9876);
    check("new_pass_ok",   32'(ok_cnt - ok0), 32'd1);
    check("new_unlocked",  32'(unlocked),     32'd1);

    // relock and a mode press land in the same cycle: relock wins.
    digit = 4'd5; mode = 1'b1; enter = 1'b1;
    @(negedge clk);
    relock = 1'b1;
    @(negedge clk);
    enter = 1'b0; relock = 1'b0; mode = 1'b0;
    repeat (4) @(negedge clk);
    check("relock_prio_locked", 32'(unlocked),  32'd0);
    check("relock_prio_idx",    32'(digit_idx), 32'd0);

    ok0 = ok_cnt;
    enter_code(16'h9876);
    check("reopen_ok", 32'(ok_cnt - ok0), 32'd1);
    mode = 1'b1;
    press(4'd0);
    mode = 1'b0;
    press(4'd5); press(4'd5);
    relock = 1'b1;
    repeat (2) @(negedge clk);
    relock = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_locked", 32'(unlocked),  32'd0);
    check("abort_idx",    32'(digit_idx), 32'd0);
    ok0 = ok_cnt;
    enter_code(16'h9876);
    check("abort_old_pass_ok", 32'(ok_cnt - ok0), 32'd1);

    // Async reset in the middle of a lockout.
    relock = 1'b1;
    repeat (2) @(negedge clk);
    relock = 1'b0;
    repeat (3) enter_code(16'h1111);
    check("pre_rst_lockout", 32'(lockout), 32'd1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_cd",      32'(count_down), 32'd0);
    check("mid_rst_lockout", 32'(lockout),    32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    ok0 = ok_cnt;
    enter_code(16'h1234);
    check("rst_pass_restored", 32'(ok_cnt - ok0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
